memory_controller_eeg: RTL and testbench

MEMORY_CONTROLLER_EEG -- requirements
Module: memory_controller_eeg

---
 rtl/memory_controller_eeg_if.sv | 34 +++
 rtl/memory_controller_eeg.sv | 116 +++++++++++
 tb/tb_memory_controller_eeg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_eeg_if.sv
// memory_controller_eeg_if: load, read, response and SRAM-wrapper signals of the EEG memory controller
// master: load source, read requester, response sink and memory wrapper (drives *_valid, data, resp_ready, *_dout)
// slave : the controller (drives *_ready, load_err, resp_*, we, wrapper addresses and din)
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
interface memory_controller_eeg_if #(
    parameter int sram_addr_width = 7,
    parameter int load_width = 80
);
    logic load_valid, load_ready, load_err;
    logic [sram_addr_width-1:0] load_addr;
    logic [load_width-1:0] load_data;
    logic rd_valid, rd_ready;
    logic [sram_addr_width-1:0] rd_im_addr, rd_pos_addr, rd_neg_addr;
    logic resp_valid, resp_ready, resp_err;
    logic [`HV_DIMENSION-1:0] resp_im, resp_pos, resp_neg;
    logic we;
    logic [sram_addr_width-1:0] im_addr, projm_pos_addr, projm_neg_addr;
    logic [`HV_DIMENSION-1:0] im_din, projm_pos_din, projm_neg_din;
    logic [`HV_DIMENSION-1:0] im_dout, projm_pos_dout, projm_neg_dout;
    modport master (
        output load_valid, load_addr, load_data, rd_valid, rd_im_addr, rd_pos_addr, rd_neg_addr,
               resp_ready, im_dout, projm_pos_dout, projm_neg_dout,
        input  load_ready, load_err, rd_ready, resp_valid, resp_err, resp_im, resp_pos, resp_neg,
               we, im_addr, projm_pos_addr, projm_neg_addr, im_din, projm_pos_din, projm_neg_din
    );
    modport slave (
        input  load_valid, load_addr, load_data, rd_valid, rd_im_addr, rd_pos_addr, rd_neg_addr,
               resp_ready, im_dout, projm_pos_dout, projm_neg_dout,
        output load_ready, load_err, rd_ready, resp_valid, resp_err, resp_im, resp_pos, resp_neg,
               we, im_addr, projm_pos_addr, projm_neg_addr, im_din, projm_pos_din, projm_neg_din
    );
endinterface

// File: rtl/memory_controller_eeg.sv
// memory_controller_eeg: stages 75-beat row loads into IM/ProjM-pos/ProjM-neg and serves 3-address reads
// clk   : rising-edge clock
// rst_n : synchronous active-low reset
// bus   : slave side of memory_controller_eeg_if (load beats, read requests, responses, SRAM wrapper)
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
module memory_controller_eeg #(
    parameter int sram_addr_width = 7,
    parameter int num_rows = 112,
    parameter int load_width = 80
) (
    input logic clk,
    input logic rst_n,
    memory_controller_eeg_if.slave bus
);
    localparam int c_hv = `HV_DIMENSION;
    localparam int c_beats = c_hv / load_width;
    localparam int c_kw = $clog2(c_beats);
    localparam logic [c_kw-1:0] c_klast = c_kw'(c_beats - 1);
    localparam logic [sram_addr_width:0] c_rows = (sram_addr_width + 1)'(num_rows);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, READ, CAPT, RESP} state_t;
    state_t r_state, w_next;
    logic [c_kw-1:0] r_k;
    logic [1:0] r_seg;
    logic [sram_addr_width-1:0] r_row, r_rd_im, r_rd_pos, r_rd_neg;
    logic [c_hv-1:0] r_stg_im, r_stg_pos, r_stg_neg;
    logic [c_hv-1:0] r_resp_im, r_resp_pos, r_resp_neg;
    logic r_resp_err;
    logic w_load_fire, w_rd_fire, w_last_beat, w_row_bad, w_rd_bad, w_rd_phase;
    assign w_load_fire = bus.load_valid && bus.load_ready;
    assign w_rd_fire = bus.rd_valid && bus.rd_ready;
    // r_seg selects the HV being staged, r_k the beat within it
    assign w_last_beat = r_seg == 2'd2 && r_k == c_klast;
    assign w_row_bad = {1'b0, r_row} >= c_rows;
    assign w_rd_bad = {1'b0, r_rd_im} >= c_rows || {1'b0, r_rd_pos} >= c_rows || {1'b0, r_rd_neg} >= c_rows;
    assign w_rd_phase = r_state == READ || r_state == CAPT;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.load_valid ? LOAD : bus.rd_valid ? READ : IDLE;
            LOAD:    w_next = (w_load_fire && w_last_beat) ? WRITE : LOAD;
            WRITE:   w_next = IDLE;
            READ:    w_next = CAPT;
            CAPT:    w_next = RESP;
            RESP:    w_next = bus.resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        bus.load_ready = r_state == IDLE || r_state == LOAD;
        bus.rd_ready = r_state == IDLE && !bus.load_valid;
        // an out-of-range row is dropped: the write strobe never fires, the error pulses instead
        bus.we = !(r_state == WRITE && !w_row_bad);
        bus.load_err = r_state == WRITE && w_row_bad;
        bus.im_addr = r_state == WRITE ? r_row : w_rd_phase ? r_rd_im : '0;
        bus.projm_pos_addr = r_state == WRITE ? r_row : w_rd_phase ? r_rd_pos : '0;
        bus.projm_neg_addr = r_state == WRITE ? r_row : w_rd_phase ? r_rd_neg : '0;
        bus.im_din = r_stg_im;
        bus.projm_pos_din = r_stg_pos;
        bus.projm_neg_din = r_stg_neg;
        bus.resp_valid = r_state == RESP;
        bus.resp_err = r_resp_err;
        bus.resp_im = r_resp_im;
        bus.resp_pos = r_resp_pos;
        bus.resp_neg = r_resp_neg;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k <= '0;
            r_seg <= '0;
            r_row <= '0;
            r_stg_im <= '0;
            r_stg_pos <= '0;
            r_stg_neg <= '0;
            r_rd_im <= '0;
            r_rd_pos <= '0;
            r_rd_neg <= '0;
            r_resp_im <= '0;
            r_resp_pos <= '0;
            r_resp_neg <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_load_fire) begin
                if (r_state == IDLE)
                    r_row <= bus.load_addr;
                case (r_seg)
                    2'd0: r_stg_im[32'(r_k) * load_width +: load_width] <= bus.load_data;
                    2'd1: r_stg_pos[32'(r_k) * load_width +: load_width] <= bus.load_data;
                    2'd2: r_stg_neg[32'(r_k) * load_width +: load_width] <= bus.load_data;
                    default: ;
                endcase
                r_k <= r_k == c_klast ? '0 : r_k + 1'b1;
                r_seg <= w_last_beat ? 2'd0 : r_k == c_klast ? r_seg + 2'd1 : r_seg;
            end
            if (w_rd_fire) begin
                r_rd_im <= bus.rd_im_addr;
                r_rd_pos <= bus.rd_pos_addr;
                r_rd_neg <= bus.rd_neg_addr;
            end
            // wrapper data for the READ-cycle addresses is valid during CAPT
            if (r_state == CAPT) begin
                r_resp_im <= bus.im_dout;
                r_resp_pos <= bus.projm_pos_dout;
                r_resp_neg <= bus.projm_neg_dout;
                r_resp_err <= w_rd_bad;
            end
        end
    end
endmodule

// File: tb/tb_memory_controller_eeg.sv
// tb_memory_controller_eeg: directed bench with a timeline model of the controller and a behavioural SRAM wrapper
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
module tb_memory_controller_eeg;
    localparam int HV = `HV_DIMENSION;
    localparam int AW = 7;
    localparam int LW = 80;
    localparam int NR = 112;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    memory_controller_eeg_if #(.sram_addr_width(AW), .load_width(LW)) bus ();
    memory_controller_eeg #(.sram_addr_width(AW), .num_rows(NR), .load_width(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    logic [HV-1:0] mem_im [128], mem_pos [128], mem_neg [128];
    logic [HV-1:0] sh_im [128], sh_pos [128], sh_neg [128];
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_im[i] = '0; mem_pos[i] = '0; mem_neg[i] = '0;
            sh_im[i] = '0; sh_pos[i] = '0; sh_neg[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (bus.we === 1'b0) begin
            mem_im[bus.im_addr] <= bus.im_din;
            mem_pos[bus.projm_pos_addr] <= bus.projm_pos_din;
            mem_neg[bus.projm_neg_addr] <= bus.projm_neg_din;
        end
        bus.im_dout <= mem_im[bus.im_addr];
        bus.projm_pos_dout <= mem_pos[bus.projm_pos_addr];
        bus.projm_neg_dout <= mem_neg[bus.projm_neg_addr];
    end
    int n_chk = 0;
    int n_fail = 0;
    int we_lows = 0;
    int err_pulses = 0;
    bit started = 0;
    logic [HV-1:0] m_stg [3];
    logic [HV-1:0] m_resp [3];
    logic m_err;
    int m_beat, m_row, m_rd;
    bit m_wr;
    int m_ra [3];
    task automatic chk(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask
    function automatic bit p_load_ready();
        return !m_wr && m_rd == 0;
    endfunction
    function automatic bit p_rd_ready();
        return m_beat == 0 && !m_wr && m_rd == 0 && !bus.load_valid;
    endfunction
    function automatic int p_addr(input int k);
        return m_wr ? m_row : (m_rd == 1 || m_rd == 2) ? m_ra[k] : 0;
    endfunction
    always @(posedge clk) begin
        bit lr, rr;
        lr = p_load_ready();
        rr = p_rd_ready();
        if (!rst_n) begin
            started = 1;
            m_beat = 0; m_wr = 0; m_rd = 0; m_row = 0; m_err = 0;
            for (int i = 0; i < 3; i++) begin
                m_stg[i] = '0; m_resp[i] = '0; m_ra[i] = 0;
            end
        end else begin
            if (m_wr) begin
                if (m_row < NR) begin
                    sh_im[m_row] = m_stg[0]; sh_pos[m_row] = m_stg[1]; sh_neg[m_row] = m_stg[2];
                end
                m_wr = 0;
            end else if (bus.load_valid && lr) begin
                if (m_beat == 0) m_row = int'(bus.load_addr);
                m_stg[m_beat / 25][(m_beat % 25) * LW +: LW] = bus.load_data;
                if (m_beat == 74) begin
                    m_beat = 0; m_wr = 1;
                end else m_beat++;
            end
            if (m_rd == 3 && bus.resp_ready) m_rd = 0;
            else if (m_rd == 2) begin
                m_rd = 3;
                m_resp[0] = sh_im[m_ra[0]]; m_resp[1] = sh_pos[m_ra[1]]; m_resp[2] = sh_neg[m_ra[2]];
                m_err = m_ra[0] >= NR || m_ra[1] >= NR || m_ra[2] >= NR;
            end else if (m_rd == 1) m_rd = 2;
            else if (m_rd == 0 && bus.rd_valid && rr) begin
                m_rd = 1;
                m_ra[0] = int'(bus.rd_im_addr); m_ra[1] = int'(bus.rd_pos_addr); m_ra[2] = int'(bus.rd_neg_addr);
            end
        end
    end
    always @(negedge clk) begin
        if (started) begin
            chk("load_ready", bus.load_ready, p_load_ready());
            chk("rd_ready", bus.rd_ready, p_rd_ready());
            chk("we", bus.we, !(m_wr && m_row < NR));
            chk("load_err", bus.load_err, m_wr && m_row >= NR);
            chk("im_addr", bus.im_addr, p_addr(0));
            chk("pos_addr", bus.projm_pos_addr, p_addr(1));
            chk("neg_addr", bus.projm_neg_addr, p_addr(2));
            chk("im_din", bus.im_din, m_stg[0]);
            chk("pos_din", bus.projm_pos_din, m_stg[1]);
            chk("neg_din", bus.projm_neg_din, m_stg[2]);
            chk("resp_valid", bus.resp_valid, m_rd == 3);
            chk("resp_err", bus.resp_err, m_err);
            chk("resp_im", bus.resp_im, m_resp[0]);
            chk("resp_pos", bus.resp_pos, m_resp[1]);
            chk("resp_neg", bus.resp_neg, m_resp[2]);
            if (bus.we === 1'b0) we_lows++;
            if (bus.load_err === 1'b1) err_pulses++;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    function automatic logic [LW-1:0] pat(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {10{b}};
    endfunction
    task automatic randomize_inputs();
        bus.load_valid = 1'($urandom); bus.rd_valid = 1'($urandom); bus.resp_ready = 1'($urandom);
        bus.load_addr = AW'($urandom); bus.load_data = {$urandom, $urandom, 16'($urandom)};
        bus.rd_im_addr = AW'($urandom); bus.rd_pos_addr = AW'($urandom); bus.rd_neg_addr = AW'($urandom);
    endtask
    task automatic load_row(input int row, input int base, input int nbeats, input int gap);
        for (int i = 0; i < nbeats; i++) begin
            if (gap != 0 && i % gap == gap - 1) begin
                bus.load_valid = 1'b0;
                tick();
            end
            bus.load_valid = 1'b1;
            bus.load_addr = i == 0 ? AW'(row) : AW'(i);
            bus.load_data = pat(base + i);
            tick();
        end
        bus.load_valid = 1'b0;
    endtask
    task automatic read(input int a0, input int a1, input int a2, input int hold, output int waited);
        bit acc;
        bus.rd_valid = 1'b1;
        bus.rd_im_addr = AW'(a0); bus.rd_pos_addr = AW'(a1); bus.rd_neg_addr = AW'(a2);
        waited = 0;
        do begin
            mid();
            acc = bus.rd_ready;
            tick();
            waited++;
        end while (!acc && waited < 200);
        if (!acc) chk("rd_accept_timeout", 1, 0);
        bus.rd_valid = 1'b0;
        mid();
        chk("lat_after_e0", bus.resp_valid, 0);
        tick(); mid();
        chk("lat_after_e1", bus.resp_valid, 0);
        tick(); mid();
        chk("lat_after_e2", bus.resp_valid, 1);
        for (int i = 0; i <= hold; i++) tick();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int w, wb, eb;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        mid();
        chk("rst_we", bus.we, 1);
        chk("rst_load_err", bus.load_err, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_im_addr", bus.im_addr, 0);
        chk("rst_resp_im", bus.resp_im, 0);
        tick();
        bus.load_valid = 0; bus.rd_valid = 0; bus.resp_ready = 0;
        rst_n = 1'b1;
        tick(); mid();
        chk("rst_load_ready", bus.load_ready, 1);
        chk("rst_rd_ready", bus.rd_ready, 1);
        tick();
        wb = we_lows;
        load_row(5, 0, 75, 0);
        mid();
        chk("wr5_we", bus.we, 0);
        chk("wr5_im_addr", bus.im_addr, 5);
        chk("wr5_neg_addr", bus.projm_neg_addr, 5);
        chk("wr5_im_din_b0", bus.im_din[79:0], 80'h0);
        chk("wr5_neg_din_b74", bus.projm_neg_din[HV-1 -: LW], {10{8'h4A}});
        tick(); mid();
        chk("after_wr5_we", bus.we, 1);
        chk("after_wr5_addr", bus.im_addr, 0);
        tick(); tick();
        chk("one_write_row5", we_lows - wb, 1);
        read(5, 5, 5, 4, w);
        chk("rd5_im_b1", bus.resp_im[159:80], {10{8'h01}});
        chk("rd5_pos_b25", bus.resp_pos[79:0], {10{8'h19}});
        chk("rd5_pos_b49", bus.resp_pos[HV-1 -: LW], {10{8'h31}});
        chk("rd5_neg_b74", bus.resp_neg[HV-1 -: LW], {10{8'h4A}});
        chk("rd5_err", bus.resp_err, 0);
        bus.rd_valid = 1'b1;
        bus.rd_im_addr = 5; bus.rd_pos_addr = 5; bus.rd_neg_addr = 5;
        bus.load_valid = 1'b1; bus.load_addr = 9; bus.load_data = pat(100);
        mid();
        chk("prio_rd_ready", bus.rd_ready, 0);
        chk("prio_load_ready", bus.load_ready, 1);
        load_row(9, 100, 75, 0);
        read(5, 5, 5, 0, w);
        chk("prio_read_after_write", w, 2);
        read(9, 9, 9, 0, w);
        chk("rd9_im_b0", bus.resp_im[79:0], {10{8'h64}});
        wb = we_lows;
        eb = err_pulses;
        load_row(112, 200, 75, 0);
        tick(); tick();
        chk("row112_err_pulses", err_pulses - eb, 1);
        chk("row112_no_write", we_lows - wb, 0);
        read(112, 5, 5, 0, w);
        chk("rd112_err", bus.resp_err, 1);
        wb = we_lows;
        load_row(7, 50, 41, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load_row(3, 128, 75, 7);
        tick(); tick();
        chk("abort_one_write", we_lows - wb, 1);
        read(3, 3, 3, 0, w);
        chk("rd3_im_b0", bus.resp_im[79:0], {10{8'h80}});
        chk("rd3_neg_b74", bus.resp_neg[HV-1 -: LW], {10{8'hCA}});
        read(7, 7, 7, 0, w);
        chk("rd7_unwritten", bus.resp_im, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
